// File: rtl/uart_engine.sv
// uart_engine: 8N1 UART transmitter and receiver with a fixed clocks-per-bit
// divisor. The TX and RX paths share no state and can run at the same time.
module uart_engine #(
  parameter int DIVISOR = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       rx,
  output logic       tx,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err
);

  // Timer reload values: a full bit period, and half a period so that the
  // receiver lands in the middle of the start bit.
  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Transmit path state.
  state_t      tx_state;
  logic [15:0] tx_timer;
  logic [2:0]  tx_bits;
  logic [7:0]  tx_shift;

  // Receive path state.
  state_t      rx_state;
  logic [15:0] rx_timer;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_hold;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_fall;

  // A start bit begins where the synchronised line drops from 1 to 0.
  assign rx_fall = rx_prev & ~rx_s2;

  // TX FSM: serialise start bit, eight data bits LSB first, then stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_timer <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (tx_req) begin
            tx_shift <= tx_data;
            tx       <= 1'b0;
            tx_timer <= BIT_LAST;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_timer == 16'd0) begin
            tx       <= tx_shift[0];
            tx_timer <= BIT_LAST;
            tx_bits  <= 3'd0;
            tx_state <= DATA;
          end else begin
            tx_timer <= tx_timer - 16'd1;
          end
        end
        DATA: begin
          if (tx_timer == 16'd0) begin
            tx_timer <= BIT_LAST;
            if (tx_bits == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              // Drive the next bit straight from the pre-shift register so
              // tx and the shift register stay in step.
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
              tx_bits  <= tx_bits + 3'd1;
            end
          end else begin
            tx_timer <= tx_timer - 16'd1;
          end
        end
        STOP: begin
          if (tx_timer == 16'd0) begin
            tx_state <= IDLE;
          end else begin
            tx_timer <= tx_timer - 16'd1;
            // Registered strobe: set one clock early so it is high on the
            // final stop-bit clock.
            if (tx_timer == 16'd1) begin
              tx_ready <= 1'b1;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Two-flop synchroniser on rx plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX FSM: validate start at its centre, sample data centres, check stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state  <= IDLE;
      rx_timer  <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      rx_hold   <= 1'b0;
      rx_data   <= 8'h00;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_timer <= HALF_LAST;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_timer == 16'd0) begin
            if (!rx_s2) begin
              rx_timer <= BIT_LAST;
              rx_bits  <= 3'd0;
              rx_state <= DATA;
            end else begin
              // Line went back high: a glitch, not a start bit.
              rx_state <= IDLE;
            end
          end else begin
            rx_timer <= rx_timer - 16'd1;
          end
        end
        DATA: begin
          if (rx_timer == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_timer <= BIT_LAST;
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) begin
              rx_state <= STOP;
            end
          end else begin
            rx_timer <= rx_timer - 16'd1;
          end
        end
        STOP: begin
          if (rx_hold) begin
            // After a bad stop bit, wait out any break before re-arming.
            if (rx_s2) begin
              rx_hold  <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (rx_timer == 16'd0) begin
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_ready <= 1'b1;
              rx_state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_hold   <= 1'b1;
            end
          end else begin
            rx_timer <= rx_timer - 16'd1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_engine.sv
// tb_uart_engine: randomised self-checking bench for uart_engine (DIVISOR=8).
`timescale 1ns/1ps
module tb_uart_engine;

  localparam int  D      = 8;
  localparam real BIT_NS = 80.0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx = 1'b1;
  logic       tx;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;

  // Receive-side observations gathered by the monitor.
  int         rdy_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rdy_byte = 8'h00;
  logic [7:0] exp_rx = 8'h00;

  uart_engine #(.DIVISOR(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .rx       (rx),
    .tx       (tx),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of an 8N1 frame at bit slot idx (0 start, 1..8 data, 9+ stop/idle).
  function automatic logic frame_level(input logic [7:0] d, input int idx);
    if (idx <= 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Count receive strobes and remember the byte presented with rx_ready.
  always @(negedge clk) begin
    if (rx_ready === 1'b1) begin
      rdy_cnt++;
      rdy_byte = rx_data;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  // Launch one byte and check every clock of the frame; optionally fire an
  // extra request mid-frame that must be ignored.
  task automatic tx_frame(input logic [7:0] d, input int ignore_at);
    @(negedge clk);
    check_value("tx_idle_before", tx, 1);
    check_value("tx_ready_before", tx_ready, 0);
    tx_req  = 1'b1;
    tx_data = d;
    for (int c = 1; c <= 10 * D; c++) begin
      @(negedge clk);
      tx_req  = 1'b0;
      tx_data = 8'($urandom);
      check_value("tx_line", tx, frame_level(d, (c - 1) / D));
      check_value("tx_ready", tx_ready, (c == 10 * D));
      if (c == ignore_at) tx_req = 1'b1;
    end
    tx_req = 1'b0;
    $display("tx frame %02h done", d);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_bit, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  // Send a good frame and expect exactly one rx_ready with that byte.
  task automatic rx_case(input logic [7:0] d, input real bit_ns);
    int r0;
    int e0;
    r0 = rdy_cnt;
    e0 = err_cnt;
    rx_send(d, 1'b1, bit_ns);
    rx = 1'b1;
    #(2.0 * BIT_NS);
    check_value("rx_ready_count", rdy_cnt - r0, 1);
    check_value("rx_byte", rdy_byte, d);
    check_value("rx_data_held", rx_data, d);
    check_value("frame_err_count", err_cnt - e0, 0);
    exp_rx = d;
    $display("rx frame %02h bit_ns %0.2f received %02h", d, bit_ns, rdy_byte);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int e0;
    logic [7:0] prev;
    logic [7:0] d1;
    logic [7:0] d2;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_req  = 1'($urandom);
      tx_data = 8'($urandom);
      rx      = 1'($urandom);
      check_value("rst_tx", tx, 1);
      check_value("rst_tx_ready", tx_ready, 0);
      check_value("rst_rx_ready", rx_ready, 0);
      check_value("rst_frame_err", frame_err, 0);
      check_value("rst_rx_data", rx_data, 8'h00);
    end
    tx_req = 1'b0;
    rx     = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_value("idle_tx", tx, 1);
      check_value("idle_tx_ready", tx_ready, 0);
    end
    check_value("idle_rx_strobes", rdy_cnt + err_cnt, 0);
    $display("reset check done");

    // Single byte with an ignored request at cycle 40, then back-to-back.
    tx_frame(8'hA5, 40);
    tx_frame(8'h00, -1);
    tx_frame(8'hFF, -1);

    // Good receive frames at nominal and +/-3 % bit period.
    @(negedge clk);
    rx_case(8'h3C, BIT_NS);
    rx_case(8'h3C, BIT_NS * 1.03);
    rx_case(8'h3C, BIT_NS * 0.97);

    // Short low glitch on an idle line must produce nothing.
    r0 = rdy_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    #30;
    rx = 1'b1;
    #(3.0 * BIT_NS);
    check_value("glitch_rx_ready", rdy_cnt - r0, 0);
    check_value("glitch_frame_err", err_cnt - e0, 0);
    $display("rx glitch done");
    rx_case(8'($urandom), BIT_NS);

    // Bad stop bit followed by a long break: one error, data kept.
    prev = exp_rx;
    r0 = rdy_cnt;
    e0 = err_cnt;
    rx_send(8'h55, 1'b0, BIT_NS);
    #(50.0 * BIT_NS);
    rx = 1'b1;
    #(2.0 * BIT_NS);
    check_value("break_frame_err", err_cnt - e0, 1);
    check_value("break_rx_ready", rdy_cnt - r0, 0);
    check_value("break_rx_data", rx_data, prev);
    $display("rx break done, rx_data %02h", rx_data);
    rx_case(8'($urandom), BIT_NS);

    // Concurrent random traffic on both paths.
    for (int k = 0; k < 6; k++) begin
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      fork
        tx_frame(d1, (k % 2 == 0) ? int'($urandom_range(2, 10 * D - 1)) : -1);
        begin
          @(negedge clk);
          #($urandom_range(0, 9));
          rx_case(d2, BIT_NS);
        end
      join
    end

    // Reset in the middle of TX data bit 4 and RX data bit 4.
    d1 = 8'($urandom) & 8'hEF;
    d2 = 8'($urandom);
    r0 = rdy_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data = d1;
    tx_req  = 1'b1;
    rx      = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      tx_req = 1'b0;
      rx     = frame_level(d2, c / D);
    end
    check_value("pre_reset_tx_low", tx, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("midrst_tx", tx, 1);
    check_value("midrst_rx_ready", rx_ready, 0);
    check_value("midrst_rx_data", rx_data, 8'h00);
    exp_rx = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    #(12.0 * BIT_NS);
    check_value("postrst_rx_ready", rdy_cnt - r0, 0);
    check_value("postrst_frame_err", err_cnt - e0, 0);
    check_value("postrst_tx", tx, 1);
    $display("mid-frame reset done");
    fork
      tx_frame(8'h81, -1);
      begin
        @(negedge clk);
        rx_case(8'h81, BIT_NS);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
